wb_openram_banked: RTL and testbench

- Wishbone slave fronting BANKS sky130_sram_1kbyte_1rw1r_32x256_8 macros, giving a contiguous BANKS x 1 KB memory in the user project area.
- Adds the following:
  - registered request FSM
  - configurable wait states
  - registered read data
  - bank decode
  - cycle-abort handling
  - optional bus error for unmapped addresses
- Port 1 of every macro is tied off: clk1=0, csb1=1, addr1=0.

---
 rtl/wb_openram_banked.sv | 160 ++++++++++++++++
 tb/tb_wb_openram_banked.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_openram_banked.sv
// wb_openram_banked: Wishbone slave over BANKS 1 KB single-port SRAM banks.
// Define WB_OPENRAM_ERR_EN to answer unmapped in-window accesses with wbs_err_o.

module wb_openram_macro (
   input  logic        i_clk,
   input  logic        i_csb,
   input  logic        i_web,
   input  logic [3:0]  i_wmask,
   input  logic [7:0]  i_addr,
   input  logic [31:0] i_din,
   output logic [31:0] o_dout
);
   logic [31:0] r_mem [256];

   // port 0 of the macro: masked write or registered read when selected
   always_ff @(posedge i_clk) begin
      if (!i_csb) begin
         if (!i_web) begin
            for (int i = 0; i < 4; i++)
               if (i_wmask[i])
                  r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
         end else begin
            o_dout <= r_mem[i_addr];
         end
      end
   end
endmodule

module wb_openram_banked #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK   = 32'hFFFF_E000,
   parameter int unsigned BANKS       = 4,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_err_o
);
   localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam logic [1:0] WS     = WAIT_STATES[1:0];

   logic [1:0]    r_state;
   logic [1:0]    r_cnt;
   logic [BW-1:0] r_bank;
   logic          r_we;
   logic          r_unmap;
   logic          r_ack;
   logic [31:0]   r_dat;

   logic          w_hit;
   logic          w_req;
   logic          w_mapped;
   logic          w_go;
   logic [BW-1:0] w_bank;
   logic [31:0]   w_dout [BANKS];
   logic [BANKS-1:0] w_csb0;

   assign w_hit    = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
   assign w_req    = wbs_stb_i & wbs_cyc_i & w_hit;
   // full 3-bit field is compared so high banks never alias low ones
   assign w_mapped = {29'd0, wbs_adr_i[12:10]} < BANKS;
   assign w_bank   = wbs_adr_i[10 +: BW];
   assign w_go     = wb_rst_ni & (r_state == S_IDLE)
                   & w_req & w_mapped;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign w_csb0[b] = ~(w_go & (w_bank == BW'(b)));
      wb_openram_macro u_mem (
         .i_clk   (wb_clk_i),
         .i_csb   (w_csb0[b]),
         .i_web   (~wbs_we_i),
         .i_wmask (wbs_sel_i),
         .i_addr  (wbs_adr_i[9:2]),
         .i_din   (wbs_dat_i),
         .o_dout  (w_dout[b])
      );
   end

`ifdef WB_OPENRAM_ERR_EN
   logic r_err;
   assign wbs_err_o = r_err;
`else
   assign wbs_err_o = 1'b0;
`endif
   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;

   // request FSM: capture, wait states, one-cycle response
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_bank  <= '0;
         r_we    <= 1'b0;
         r_unmap <= 1'b0;
         r_ack   <= 1'b0;
         r_dat   <= 32'h0;
`ifdef WB_OPENRAM_ERR_EN
         r_err   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_bank  <= w_bank;
                  r_we    <= wbs_we_i;
                  r_unmap <= ~w_mapped;
                  r_cnt   <= WS;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 2'd0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  if (!r_we) begin
`ifdef WB_OPENRAM_ERR_EN
                     if (!r_unmap)
                        r_dat <= w_dout[r_bank];
`else
                     r_dat <= r_unmap ? 32'h0
                                      : w_dout[r_bank];
`endif
                  end
                  if (wbs_cyc_i) begin
`ifdef WB_OPENRAM_ERR_EN
                     r_err <= r_unmap;
                     r_ack <= ~r_unmap;
`else
                     r_ack <= 1'b1;
`endif
                     r_state <= S_ACK;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_ACK: begin
               r_ack   <= 1'b0;
`ifdef WB_OPENRAM_ERR_EN
               r_err   <= 1'b0;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_openram_banked.sv
// tb_wb_openram_banked: vector table, corner sequences, random traffic.
// Built with BANKS=4, WAIT_STATES=2; WB_OPENRAM_ERR_EN changes expectations.

module tb_wb_openram_banked;
   localparam int unsigned BANKS = 4;
   localparam int unsigned WS    = 2;
   localparam int          LAT   = 1 + WS;
`ifdef WB_OPENRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat = 32'h0;
   logic [31:0] adr = 32'h0;
   logic        ack;
   logic        err;
   logic [31:0] rdat;

   int checks = 0;
   int failures = 0;

   wb_openram_banked #(
      .BASE_ADDR   (32'h3000_0000),
      .ADDR_MASK   (32'hFFFF_E000),
      .BANKS       (BANKS),
      .WAIT_STATES (WS)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .wbs_err_o (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        ack;
      logic        err;
      logic [31:0] rd;
      logic        chkd;
      logic [3:0]  csb;
   } vec_t;

   vec_t        tv[$];
   logic [31:0] m_mem [BANKS][256];
   logic [31:0] m_dout;

   function automatic vec_t mk(
      logic w, logic [31:0] a, logic [3:0] s,
      logic [31:0] d, logic ea, logic ee,
      logic [31:0] ed, logic cd, logic [3:0] ec);
      vec_t v;
      v.we = w; v.adr = a; v.sel = s; v.dat = d;
      v.ack = ea; v.err = ee; v.rd = ed;
      v.chkd = cd; v.csb = ec;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output logic o_ack, output logic o_err,
                       output logic [31:0] o_rd, output int o_lat,
                       output logic [3:0] o_csb);
      stb = 1'b1; cyc = 1'b1; we = w;
      adr = a; sel = s; dat = d;
      o_ack = 1'b0; o_err = 1'b0; o_rd = 32'h0; o_lat = -1;
      #1 o_csb = dut.w_csb0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (ack || err) begin
            o_ack = ack; o_err = err; o_rd = rdat; o_lat = k;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run(input string nm, input logic w,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic ea,
                      input logic ee, input logic [31:0] ed,
                      input logic cd, input logic [3:0] ec);
      logic g_ack, g_err;
      logic [31:0] g_rd;
      logic [3:0] g_csb;
      int g_lat;
      int e_lat;
      xfer(w, a, s, d, g_ack, g_err, g_rd, g_lat, g_csb);
      e_lat = (ea || ee) ? LAT : -1;
      chk({nm, ".ack"}, 32'(g_ack), 32'(ea));
      chk({nm, ".err"}, 32'(g_err), 32'(ee));
      chk({nm, ".lat"}, 32'(g_lat), 32'(e_lat));
      chk({nm, ".csb"}, 32'(g_csb), 32'(ec));
      if (cd) chk({nm, ".dat"}, g_rd, ed);
   endtask

   task automatic count_resp(input int n, output int r);
      r = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (ack || err) r++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int resp;
      int lat;
      int b, w;
      bit miss, mapped;
      logic [31:0] a, d, ed;
      logic [3:0] s, ec;
      logic wr, ea, ee;

      // reset state
      #3;
      chk("rst.ack", 32'(ack), 32'h0);
      chk("rst.err", 32'(err), 32'h0);
      chk("rst.dat", rdat, 32'h0);
      chk("rst.csb", 32'(dut.w_csb0), 32'hF);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vector table
      tv.push_back(mk(1, 32'h3000_0004, 4'hF, 32'hDEADBEEF,
                      1, 0, 0, 0, 4'hE));
      tv.push_back(mk(0, 32'h3000_0004, 4'hF, 0,
                      1, 0, 32'hDEADBEEF, 1, 4'hE));
      tv.push_back(mk(0, 32'h3000_0006, 4'hF, 0,
                      1, 0, 32'hDEADBEEF, 1, 4'hE));
      tv.push_back(mk(1, 32'h3000_0010, 4'hF, 32'h11223344,
                      1, 0, 0, 0, 4'hE));
      tv.push_back(mk(1, 32'h3000_0010, 4'h8, 32'hAA000000,
                      1, 0, 0, 0, 4'hE));
      tv.push_back(mk(0, 32'h3000_0010, 4'hF, 0,
                      1, 0, 32'hAA223344, 1, 4'hE));
      for (int n = 0; n < 4; n++)
         tv.push_back(mk(1, 32'h3000_0000 + 32'(n) * 32'h400,
                         4'hF, 32'(n), 1, 0, 0, 0,
                         ~(4'h1 << n)));
      for (int n = 0; n < 4; n++)
         tv.push_back(mk(0, 32'h3000_0000 + 32'(n) * 32'h400,
                         4'hF, 0, 1, 0, 32'(n), 1,
                         ~(4'h1 << n)));
      tv.push_back(mk(0, 32'h3000_1400, 4'hF, 0, ~ERR_EN,
                      ERR_EN, ERR_EN ? 32'h3 : 32'h0, 1, 4'hF));
      tv.push_back(mk(1, 32'h3000_1400, 4'hF, 32'h55,
                      ~ERR_EN, ERR_EN, 0, 0, 4'hF));
      tv.push_back(mk(0, 32'h3000_0400, 4'hF, 0,
                      1, 0, 32'h1, 1, 4'hD));
      tv.push_back(mk(1, 32'h3000_1000, 4'hF, 32'hFF,
                      ~ERR_EN, ERR_EN, 0, 0, 4'hF));
      tv.push_back(mk(0, 32'h3000_0000, 4'hF, 0,
                      1, 0, 32'h0, 1, 4'hE));
      tv.push_back(mk(0, 32'h3000_1C00, 4'hF, 0, ~ERR_EN,
                      ERR_EN, 32'h0, 1, 4'hF));
      tv.push_back(mk(0, 32'h3100_0000, 4'hF, 0,
                      0, 0, 0, 0, 4'hF));
      for (int i = 0; i < tv.size(); i++)
         run($sformatf("tv%0d", i), tv[i].we, tv[i].adr,
             tv[i].sel, tv[i].dat, tv[i].ack, tv[i].err,
             tv[i].rd, tv[i].chkd, tv[i].csb);

      // strobe held through ACK must not retrigger
      adr = 32'h3000_0100; we = 1'b0; sel = 4'hF;
      stb = 1'b1; cyc = 1'b1;
      lat = -1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (ack) begin lat = k; break; end
      end
      chk("hold.lat", 32'(lat), 32'(LAT));
      chk("hold.csb", 32'(dut.w_csb0), 32'hF);
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0;
      count_resp(6, resp);
      chk("hold.resp", 32'(resp), 32'h0);

      // read aborted in WAIT
      adr = 32'h3000_0004; we = 1'b0;
      stb = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0;
      count_resp(6, resp);
      chk("abrt_rd.resp", 32'(resp), 32'h0);

      // aborted write still commits
      adr = 32'h3000_0014; we = 1'b1; dat = 32'hCAFEF00D;
      stb = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      count_resp(6, resp);
      chk("abrt_wr.resp", 32'(resp), 32'h0);
      run("abrt_wr.rd", 0, 32'h3000_0014, 4'hF, 0,
          1, 0, 32'hCAFEF00D, 1, 4'hE);

      // reset pulse mid-WAIT
      adr = 32'h3000_0004; we = 1'b0;
      stb = 1'b1; cyc = 1'b1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mrst.ack", 32'(ack), 32'h0);
      chk("mrst.err", 32'(err), 32'h0);
      chk("mrst.dat", rdat, 32'h0);
      chk("mrst.csb", 32'(dut.w_csb0), 32'hF);
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      count_resp(5, resp);
      chk("mrst.resp", 32'(resp), 32'h0);
      run("mrst.rd", 0, 32'h3000_0004, 4'hF, 0,
          1, 0, 32'hDEADBEEF, 1, 4'hE);

      // preload model and DUT, words 0..7 of every bank
      for (int bb = 0; bb < BANKS; bb++)
         for (int ww = 0; ww < 8; ww++) begin
            d = $urandom;
            m_mem[bb][ww] = d;
            run("init", 1, 32'h3000_0000 | (32'(bb) << 10)
                | (32'(ww) << 2), 4'hF, d, 1, 0, 0, 0,
                ~(4'h1 << bb));
         end
      m_dout = m_mem[0][0];
      run("sync", 0, 32'h3000_0000, 4'hF, 0, 1, 0,
          m_dout, 1, 4'hE);

      // random traffic against the reference model
      for (int t = 0; t < 80; t++) begin
         b = $urandom_range(0, 7);
         w = $urandom_range(0, 7);
         miss = ($urandom_range(0, 7) == 0);
         wr = $urandom_range(0, 1) == 1;
         s = 4'($urandom_range(0, 15));
         d = $urandom;
         a = (miss ? 32'h3000_2000 : 32'h3000_0000)
           | (32'(b) << 10) | (32'(w) << 2)
           | 32'($urandom_range(0, 3));
         mapped = !miss && (b < BANKS);
         ea = !miss && (mapped || !ERR_EN);
         ee = !miss && !mapped && ERR_EN;
         ec = mapped ? ~(4'h1 << b) : 4'hF;
         ed = m_dout;
         if (!miss && !wr)
            ed = mapped ? m_mem[b][w]
                        : (ERR_EN ? m_dout : 32'h0);
         run($sformatf("rnd%0d", t), wr, a, s, d,
             ea, ee, ed, !miss && !wr, ec);
         if (!miss && !wr) m_dout = ed;
         if (mapped && wr)
            for (int i = 0; i < 4; i++)
               if (s[i]) m_mem[b][w][8*i +: 8] = d[8*i +: 8];
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
